freq_meter: RTL and testbench

Measures the frequency of an external, asynchronous square-wave input by counting its rising edges over a fixed gate window timed by `mclk`. It works in the opposite direction to the clock divider: the divider derives slow clocks from `mclk`, and this block recovers the rate of a slow signal in `mclk` cycles. It sits beside the divider in the board top level. Its result feeds the seven-segment display path as a plain count plus a one-cycle valid strobe.

---
 rtl/freq_meter.sv | 105 ++++++++++
 tb/tb_freq_meter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: counts sig_in rising edges over a GATE_CYCLES mclk window.
// Emits a saturating count, a one-cycle valid strobe and an overflow flag.
module freq_meter #(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int CNT_W       = 28
) (
  input  logic             mclk,
  input  logic             clr,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             ovf,
  output logic             busy
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_nx;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic [GW-1:0]    gate;
  logic [CNT_W-1:0] cnt;
  logic             cnt_ovf;
  logic             cnt_full;
  logic             run;
  logic             tc;

  // synchronizer keeps running in IDLE so re-enable sees no stale edge
  always_ff @(posedge mclk or posedge clr) begin
    if (clr) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise     = s2 & ~s3;
  assign cnt_full = (cnt == CMAX);

  always_ff @(posedge mclk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = en ? RUN : IDLE;
      RUN:     state_nx = en ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    run  = (state == RUN);
    busy = run;
    tc   = run && (gate == LAST);
  end

  // a window ends at TC even if en drops there; elsewhere en low aborts it
  always_ff @(posedge mclk or posedge clr) begin
    if (clr) begin
      gate    <= '0;
      cnt     <= '0;
      cnt_ovf <= 1'b0;
    end else if (!run || tc || !en) begin
      gate    <= '0;
      cnt     <= '0;
      cnt_ovf <= 1'b0;
    end else begin
      gate <= gate + GW'(1);
      if (rise) begin
        if (cnt_full) cnt_ovf <= 1'b1;
        else          cnt     <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge mclk or posedge clr) begin
    if (clr) begin
      freq  <= '0;
      ovf   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= tc;
      if (tc) begin
        freq <= (rise && !cnt_full) ? cnt + CNT_W'(1) : cnt;
        ovf  <= cnt_ovf | (rise & cnt_full);
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: two freq_meter instances (wide and 3-bit counter)
// against a windowed edge-count reference model.
module tb_freq_meter;

  localparam int G = 16;

  logic       mclk;
  logic       clr;
  logic       en;
  logic       sig_in;
  logic [7:0] freq_w;
  logic       valid_w;
  logic       ovf_w;
  logic       busy_w;
  logic [2:0] freq_s;
  logic       valid_s;
  logic       ovf_s;
  logic       busy_s;

  int total = 0;
  int bad   = 0;
  bit mon   = 0;
  int mode  = 0;
  int tg    = 0;

  // reference model state
  int h1, h2, h3;
  int run, pos, cnt;
  int m_valid, m_fw, m_ow, m_fs, m_os;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) u_dut (
    .mclk(mclk), .clr(clr), .en(en), .sig_in(sig_in),
    .freq(freq_w), .valid(valid_w), .ovf(ovf_w), .busy(busy_w)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(3)) u_sat (
    .mclk(mclk), .clr(clr), .en(en), .sig_in(sig_in),
    .freq(freq_s), .valid(valid_s), .ovf(ovf_s), .busy(busy_s)
  );

  initial mclk = 0;
  always #5 mclk = ~mclk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: a rise is seen two samples late; each window counts the rises
  // seen during its G cycles, result clipped to the counter range.
  always @(posedge mclk or posedge clr) begin
    int e;
    if (clr) begin
      h1 = 0; h2 = 0; h3 = 0;
      run = 0; pos = 0; cnt = 0;
      m_valid = 0; m_fw = 0; m_ow = 0; m_fs = 0; m_os = 0;
    end else begin
      e = (h2 == 1 && h3 == 0) ? 1 : 0;
      h3 = h2; h2 = h1; h1 = int'(sig_in);
      m_valid = 0;
      if (run == 1) begin
        cnt += e;
        if (pos == G - 1) begin
          m_valid = 1;
          m_fw = (cnt > 255) ? 255 : cnt;
          m_ow = (cnt > 255) ? 1 : 0;
          m_fs = (cnt > 7) ? 7 : cnt;
          m_os = (cnt > 7) ? 1 : 0;
          cnt = 0; pos = 0; run = int'(en);
        end else if (!en) begin
          run = 0; cnt = 0; pos = 0;
        end else begin
          pos++;
        end
      end else begin
        run = int'(en); pos = 0; cnt = 0;
      end
    end
  end

  always @(negedge mclk) begin
    if (mon) begin
      check("valid_w", int'(valid_w), m_valid);
      check("valid_s", int'(valid_s), m_valid);
      check("busy_w", int'(busy_w), run);
      check("busy_s", int'(busy_s), run);
      check("freq_w", int'(freq_w), m_fw);
      check("ovf_w", int'(ovf_w), m_ow);
      check("freq_s", int'(freq_s), m_fs);
      check("ovf_s", int'(ovf_s), m_os);
    end
  end

  task automatic tick();
    case (mode)
      1: sig_in = ~sig_in;
      2: begin
        tg++;
        if (tg % 2 == 0) sig_in = ~sig_in;
      end
      3: sig_in = 1'($urandom % 2);
      default: ;
    endcase
    @(negedge mclk);
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid_w && n < lim);
    if (!valid_w) check("valid_timeout", int'(valid_w), 1);
  endtask

  initial begin
    int n;
    int sv;
    int sum;
    int exp_w[4];
    clr = 1; en = 0; sig_in = 0;
    repeat (3) @(negedge mclk);
    check("rst_freq", int'(freq_w), 0);
    check("rst_valid", int'(valid_w), 0);
    check("rst_ovf", int'(ovf_w), 0);
    check("rst_busy", int'(busy_w), 0);
    clr = 0;
    mon = 1;

    // period-4 input
    en = 1; mode = 2;
    wait_valid(40, n);
    wait_valid(40, n);
    check("t1_freq", int'(freq_w), 4);
    check("t1_ovf", int'(ovf_w), 0);
    wait_valid(40, n);
    check("t1_period", n, G);

    // held high
    mode = 0; sig_in = 1;
    wait_valid(40, n);
    wait_valid(40, n);
    check("t2_freq", int'(freq_w), 0);
    wait_valid(40, n);
    check("t2_freq2", int'(freq_w), 0);

    // 8 rises per window: narrow counter saturates
    mode = 1;
    wait_valid(40, n);
    wait_valid(40, n);
    check("t3_sat_freq", int'(freq_s), 7);
    check("t3_sat_ovf", int'(ovf_s), 1);
    check("t3_wide_freq", int'(freq_w), 8);
    mode = 2;
    wait_valid(40, n);
    wait_valid(40, n);
    check("t3_slow_freq", int'(freq_s), 4);
    check("t3_slow_ovf", int'(ovf_s), 0);

    // abort at gate count 10, then re-enable
    wait_valid(40, n);
    repeat (10) tick();
    en = 0;
    sv = int'(freq_w);
    tick();
    check("t4_busy", int'(busy_w), 0);
    repeat (20) begin
      tick();
      check("t4_novalid", int'(valid_w), 0);
    end
    check("t4_hold", int'(freq_w), sv);
    en = 1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid_w && n < 40);
    check("t4_latency", n, 17);
    check("t4_freq", int'(freq_w), 4);

    // one rise on TC, one on the first cycle two windows later
    mode = 0; sig_in = 0;
    wait_valid(40, n);
    wait_valid(40, n);
    exp_w = '{1, 0, 1, 0};
    sum = 0;
    for (int j = 1; j <= 64; j++) begin
      sig_in = ((j >= 14 && j < 20) || j >= 31) ? 1'b1 : 1'b0;
      @(negedge mclk);
      if (j % G == 0) begin
        check("t5_valid", int'(valid_w), 1);
        check("t5_freq", int'(freq_w), exp_w[j / G - 1]);
        sum += int'(freq_w);
      end
    end
    check("t5_total", sum, 2);

    // random input and enable
    mode = 3;
    repeat (400) begin
      if ($urandom % 40 == 0) en = ~en;
      tick();
    end

    // asynchronous clear mid-window
    en = 1; mode = 2;
    wait_valid(40, n);
    repeat (5) tick();
    #2 clr = 1;
    #1;
    check("t6_freq", int'(freq_w), 0);
    check("t6_valid", int'(valid_w), 0);
    check("t6_ovf", int'(ovf_w), 0);
    check("t6_busy", int'(busy_w), 0);
    check("t6_freq_s", int'(freq_s), 0);
    @(negedge mclk);
    clr = 0; mode = 0;
    for (int m = 0; m < 17; m++) begin
      sig_in = ((m / 2) % 2 == 0) ? 1'b1 : 1'b0;
      @(negedge mclk);
    end
    check("t6_valid_after", int'(valid_w), 1);
    check("t6_freq_after", int'(freq_w), 4);
    repeat (4) tick();

    mon = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
